seg_prbs_checker: RTL and testbench

- Receive-end checker for the 7-segment LFSR pattern display.
- Samples a 7-segment glyph bus and decodes each glyph back to a 4-bit nibble.
- Locks onto the 15-state XNOR LFSR sequence and then counts symbol errors.
- Sits on the input side of a loopback/bring-up path, fed from segment outputs through ui_in.

---
 rtl/seg_prbs_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg_prbs_checker.sv | 174 +++++++++++++++++
 tb/tb_seg_prbs_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_prbs_pkg.sv
// Shared definitions for the 7-segment PRBS loopback checker.
// Provides checker state encodings, the hex glyph table, the LFSR lockup
// value and the 4-bit XNOR LFSR step function.
package seg_prbs_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned ST_W  = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_HUNT   = 2'd0;
  localparam state_t ST_VERIFY = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  // XNOR LFSR sticks at all-ones, so it can never seed the sequence.
  localparam logic [NIB_W-1:0] LFSR_LOCKUP = 4'hF;

  // Active-high glyphs, bit0=a .. bit6=g; entry i is the glyph for hex digit i.
  localparam logic [15:0][SEG_W-1:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // One step of the 15-state XNOR LFSR.
  function automatic logic [NIB_W-1:0] lfsr_next(input logic [NIB_W-1:0] n);
    return {n[2:0], ~(n[3] ^ n[2])};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment glyph to hex nibble decoder.
// Ports:
//   glyph_i      active-high glyph, bit0=a .. bit6=g
//   nibble_o_c   decoded hex digit (0 when illegal)
//   illegal_o_c  glyph is not one of the 16 hex glyphs
module seg7_decode
  import seg_prbs_pkg::*;
(
  input  logic [SEG_W-1:0] glyph_i,
  output logic [NIB_W-1:0] nibble_o_c,
  output logic             illegal_o_c
);

  // Reverse table lookup; glyphs are unique so at most one entry hits.
  always_comb begin
    nibble_o_c  = '0;
    illegal_o_c = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (glyph_i == GLYPH_TBL[i]) begin
        nibble_o_c  = NIB_W'(i);
        illegal_o_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_prbs_checker.sv
// Receive-end checker for a 7-segment LFSR pattern display.
// Decodes sampled glyphs, locks onto the 15-state XNOR LFSR sequence and
// counts symbol errors while locked.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   seg_in       sampled glyph, bit0=a .. bit6=g
//   seg_valid    sample strobe
//   err_clr      synchronous clear of err_count (wins over an increment)
//   nibble_out   last legally decoded nibble
//   glyph_err    last sample was not a legal hex glyph
//   locked       checker is in the LOCKED state
//   err_pulse    one-cycle pulse per counted error
//   err_count    saturating error count
module seg_prbs_checker
  import seg_prbs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned UNLOCK_ERRS    = 3,
  parameter int unsigned ERR_W          = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             seg_valid,
  input  logic             err_clr,
  output logic [3:0]       nibble_out,
  output logic             glyph_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_ERRS);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  logic [SEG_W-1:0] glyph_c;
  logic [NIB_W-1:0] dec_nibble_c;
  logic             dec_illegal_c;
  logic             seed_ok_c;
  logic             sym_match_c;

  state_t           state_q,     state_d;
  logic [NIB_W-1:0] expected_q,  expected_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] miss_run_q,  miss_run_d;
  logic [NIB_W-1:0] nibble_q,    nibble_d;
  logic             glyph_err_q, glyph_err_d;
  logic             locked_q,    locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

  assign glyph_c = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

  seg7_decode u_dec (
    .glyph_i     (glyph_c),
    .nibble_o_c  (dec_nibble_c),
    .illegal_o_c (dec_illegal_c)
  );

  // A legal, non-lockup symbol can seed the sequence; illegal never matches.
  assign seed_ok_c   = !dec_illegal_c && (dec_nibble_c != LFSR_LOCKUP);
  assign sym_match_c = !dec_illegal_c && (dec_nibble_c == expected_q);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_run_d  = miss_run_q;
    nibble_d    = nibble_q;
    glyph_err_d = glyph_err_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (seg_valid) begin
      glyph_err_d = dec_illegal_c;
      if (!dec_illegal_c) begin
        nibble_d = dec_nibble_c;
      end

      case (state_q)
        ST_HUNT: begin
          if (seed_ok_c) begin
            expected_d  = lfsr_next(dec_nibble_c);
            match_cnt_d = CNT_W'(1);
            state_d     = (LOCK_TGT == CNT_W'(1)) ? ST_LOCKED : ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (sym_match_c) begin
            expected_d  = lfsr_next(expected_q);
            match_cnt_d = match_cnt_q + CNT_W'(1);
            if (match_cnt_d == LOCK_TGT) begin
              state_d = ST_LOCKED;
            end
          end else if (seed_ok_c) begin
            // Re-seed from this sample rather than waiting for another.
            expected_d  = lfsr_next(dec_nibble_c);
            match_cnt_d = CNT_W'(1);
          end else begin
            match_cnt_d = '0;
            state_d     = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          // Flywheel: expected advances on every symbol, so one corrupted
          // symbol costs exactly one error.
          expected_d = lfsr_next(expected_q);
          if (sym_match_c) begin
            miss_run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            miss_run_d = miss_run_q + CNT_W'(1);
            if (miss_run_d == UNLOCK_TGT) begin
              miss_run_d  = '0;
              match_cnt_d = '0;
              state_d     = ST_HUNT;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_run_q  <= '0;
      nibble_q    <= '0;
      glyph_err_q <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_run_q  <= miss_run_d;
      nibble_q    <= nibble_d;
      glyph_err_q <= glyph_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign nibble_out = nibble_q;
  assign glyph_err  = glyph_err_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_seg_prbs_checker.sv
// Scoreboard bench for seg_prbs_checker: a reference model built on the
// sequence table pushes expected outputs per clock, a monitor compares them.
module tb_seg_prbs_checker;

  localparam int LOCK_COUNT  = 4;
  localparam int UNLOCK_ERRS = 3;
  localparam int ERR_W       = 2;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  localparam int SEQ [15] = '{0, 1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8};
  localparam logic [6:0] GLY [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0]       nib;
    logic             gerr;
    logic             lck;
    logic             pulse;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       seg_in = '0;
  logic             seg_valid = 1'b0;
  logic             err_clr = 1'b0;
  logic [3:0]       nibble_out;
  logic             glyph_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int tx_pos = 0;
  exp_t exp_q[$];

  seg_prbs_checker #(
    .LOCK_COUNT     (LOCK_COUNT),
    .UNLOCK_ERRS    (UNLOCK_ERRS),
    .ERR_W          (ERR_W),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .err_clr    (err_clr),
    .nibble_out (nibble_out),
    .glyph_err  (glyph_err),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (GLY[i] == g) return i;
    return -1;
  endfunction

  function automatic int seq_idx(input int v);
    for (int i = 0; i < 15; i++) if (SEQ[i] == v) return i;
    return -1;
  endfunction

  // Reference model: position within the known sequence plus lock rules.
  int m_state = 0;  // 0 hunt, 1 verify, 2 locked
  int m_pos = 0, m_cnt = 0, m_run = 0, m_nib = 0, m_err = 0;
  bit m_gerr = 0, m_pulse = 0, m_good;
  int m_g;
  exp_t m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pos = 0; m_cnt = 0; m_run = 0;
      m_nib = 0; m_err = 0; m_gerr = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (seg_valid) begin
        m_g    = dec(seg_in);
        m_gerr = (m_g < 0);
        if (m_g >= 0) m_nib = m_g;
        m_good = (m_g >= 0) && (m_g == SEQ[m_pos]);
        if (m_state == 2) begin
          m_pos = (m_pos + 1) % 15;
          if (m_good) m_run = 0;
          else begin
            m_pulse = 1;
            if (m_err < ERR_MAX) m_err++;
            m_run++;
            if (m_run == UNLOCK_ERRS) begin m_state = 0; m_run = 0; end
          end
        end else if (m_state == 1 && m_good) begin
          m_pos = (m_pos + 1) % 15;
          m_cnt++;
          if (m_cnt == LOCK_COUNT) m_state = 2;
        end else if (m_g >= 0 && m_g != 15) begin
          m_pos   = (seq_idx(m_g) + 1) % 15;
          m_cnt   = 1;
          m_state = (LOCK_COUNT == 1) ? 2 : 1;
        end else begin
          m_state = 0;
        end
      end
      if (err_clr) m_err = 0;
    end
    m_e.nib   = 4'(m_nib);
    m_e.gerr  = m_gerr;
    m_e.lck   = (m_state == 2);
    m_e.pulse = m_pulse;
    m_e.cnt   = ERR_W'(m_err);
    exp_q.push_back(m_e);
  end

  // Monitor: every clock presents a fresh registered output set.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("nibble_out", 32'(nibble_out), 32'(mon_e.nib));
      chk("glyph_err",  32'(glyph_err),  32'(mon_e.gerr));
      chk("locked",     32'(locked),     32'(mon_e.lck));
      chk("err_pulse",  32'(err_pulse),  32'(mon_e.pulse));
      chk("err_count",  32'(err_count),  32'(mon_e.cnt));
    end
  end

  task automatic send(input logic [6:0] g, input logic v, input logic c);
    seg_in = g; seg_valid = v; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_good(input int n);
    repeat (n) begin
      send(GLY[SEQ[tx_pos]], 1'b1, 1'b0);
      tx_pos = (tx_pos + 1) % 15;
    end
  endtask

  task automatic send_bad(input int n);
    repeat (n) begin
      send(GLY[SEQ[(tx_pos + 5) % 15]], 1'b1, 1'b0);
      tx_pos = (tx_pos + 1) % 15;
    end
  endtask

  initial begin
    logic [6:0] g;
    logic v, c;
    int r, wait_cyc;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Clean stream from reset.
    tx_pos = 0;
    send_good(100);

    // Single corruption of a 'C' glyph while locked.
    while (SEQ[tx_pos] != 12) send_good(1);
    send(7'h3A, 1'b1, 1'b0);
    tx_pos = (tx_pos + 1) % 15;
    send_good(10);

    // Loss of lock and relock.
    send_bad(3);
    send_good(8);

    // Seed rejection in HUNT.
    send_bad(3);
    send(7'h71, 1'b1, 1'b0);
    send(7'h00, 1'b1, 1'b0);
    send(GLY[7], 1'b1, 1'b0);
    tx_pos = seq_idx(14);
    send_good(6);

    // Saturation, then clear coincident with an error.
    send(7'h00, 1'b0, 1'b1);
    send_bad(2); send_good(1); send_bad(2); send_good(1); send_bad(1);
    send_good(1);
    send(GLY[SEQ[(tx_pos + 5) % 15]], 1'b1, 1'b1);
    tx_pos = (tx_pos + 1) % 15;
    send_good(5);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 19) == 0);
      if (r < 85)      g = GLY[SEQ[tx_pos]];
      else if (r < 93) g = GLY[$urandom_range(0, 15)];
      else             g = 7'($urandom);
      send(g, v, c);
      if (v) tx_pos = (tx_pos + 1) % 15;
    end

    // Async reset between edges while locked.
    send_good(20);
    send_bad(1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst nibble_out", 32'(nibble_out), 32'd0);
    chk("async_rst glyph_err",  32'(glyph_err),  32'd0);
    chk("async_rst locked",     32'(locked),     32'd0);
    chk("async_rst err_pulse",  32'(err_pulse),  32'd0);
    chk("async_rst err_count",  32'(err_count),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_good(10);

    // Drain the scoreboard.
    repeat (3) send(7'h00, 1'b0, 1'b0);
    wait_cyc = 0;
    while (exp_q.size() > 1 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard drained", 32'(exp_q.size() <= 1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
